// File: rtl/inst_fetch.sv
// Instruction fetch stage: sequential word fetch with a one-entry skid buffer
// and a branch redirect that drops any response still in flight.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_OUT,
        DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic        slot_free;
    logic [31:0] pc_inc;

    assign pc_inc    = pc_q + 32'd4;
    assign slot_free = !if_valid_q || !stall;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        if_valid_d  = if_valid_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if (branch_flag) begin
            if_valid_d = 1'b0;
            pc_d       = {branch_target[31:2], 2'b00};
            unique case (state_q)
                FETCH: begin
                    // Outstanding request keeps its address until acked.
                    if (!imem_ack) begin
                        state_d = DISCARD;
                        hold_d  = pc_q;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_inc;
                        if (slot_free) begin
                            if_pc_d    = pc_q;
                            if_inst_d  = imem_rdata;
                            if_valid_d = 1'b1;
                        end else begin
                            skid_pc_d   = pc_q;
                            skid_inst_d = imem_rdata;
                            state_d     = WAIT_OUT;
                        end
                    end else if (slot_free) begin
                        if_valid_d = 1'b0;
                    end
                end
                WAIT_OUT: begin
                    if (!stall) begin
                        if_pc_d    = skid_pc_q;
                        if_inst_d  = skid_inst_q;
                        if_valid_d = 1'b1;
                        state_d    = FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            hold_q      <= 32'd0;
            if_pc_q     <= 32'd0;
            if_inst_q   <= 32'd0;
            if_valid_q  <= 1'b0;
            skid_pc_q   <= 32'd0;
            skid_inst_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
            if_valid_q  <= if_valid_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

    assign imem_req  = (state_q == FETCH) || (state_q == DISCARD);
    assign imem_addr = (state_q == DISCARD) ? hold_q : pc_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;
    assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed boundary cases, then a random run whose
// consumed instruction stream is scored against a program-order model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] pc2;
    logic [31:0] inst2;
    logic        valid2;

    logic        ack_mode;
    logic        ack_drv;
    logic [31:0] salt;
    logic [31:0] junk;
    logic        sb_on;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    logic [63:0] exp_q[$];
    logic [31:0] gen_pc;

    always #5 clk = ~clk;

    assign imem_ack   = ack_mode ? imem_req : ack_drv;
    assign imem_rdata = imem_ack ? (imem_addr ^ salt) : junk;
    assign ack2       = req2;

    inst_fetch u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .stall         (1'b0),
        .branch_flag   (1'b0),
        .branch_target (32'd0),
        .imem_req      (req2),
        .imem_addr     (addr2),
        .imem_ack      (ack2),
        .imem_rdata    (addr2),
        .if_pc         (pc2),
        .if_inst       (inst2),
        .if_valid      (valid2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back({gen_pc, gen_pc ^ salt});
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    // Monitor: pops the model stream whenever an instruction is consumed.
    initial begin
        logic        p_pend;
        logic [31:0] p_addr;
        logic [63:0] e;
        p_pend = 1'b0;
        p_addr = 32'd0;
        forever begin
            @(negedge clk);
            if (sb_on && !rst) begin
                if (p_pend) begin
                    chk("req_hold", imem_req, 1'b1);
                    chk("addr_hold", imem_addr, p_addr);
                end
                if (imem_req) begin
                    chk("addr_align", imem_addr[1:0], 2'b00);
                end
                if (if_valid && !stall && !branch_flag) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_empty", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        pops++;
                        chk("sb_pc", if_pc, e[63:32]);
                        chk("sb_inst", if_inst, e[31:0]);
                    end
                end
                p_pend = imem_req && !imem_ack;
                p_addr = imem_addr;
            end else begin
                p_pend = 1'b0;
            end
        end
    end

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        branch_flag   = 1'b0;
        branch_target = 32'd0;
        ack_mode      = 1'b1;
        ack_drv       = 1'b0;
        salt          = 32'd0;
        junk          = 32'hDEAD_BEEF;
        sb_on         = 1'b0;
        gen_pc        = 32'd0;
        #2;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        tick();
        rst = 1'b0;

        tick();
        chk("idle_valid", if_valid, 1'b0);
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'd0);
        tick();
        chk("seq0_valid", if_valid, 1'b1);
        chk("seq0_pc", if_pc, 32'd0);
        chk("seq0_inst", if_inst, 32'd0);
        chk("wrap_pc0", pc2, 32'hFFFF_FFFC);
        chk("wrap_v0", valid2, 1'b1);
        tick();
        chk("seq1_pc", if_pc, 32'd4);
        chk("wrap_pc1", pc2, 32'd0);
        chk("wrap_inst1", inst2, 32'd0);

        stall = 1'b1;
        tick();
        chk("skid_req", imem_req, 1'b0);
        chk("skid_hold_pc", if_pc, 32'd4);
        chk("skid_hold_v", if_valid, 1'b1);
        tick();
        chk("skid_hold2", if_pc, 32'd4);
        stall = 1'b0;
        tick();
        chk("skid_out_pc", if_pc, 32'd8);
        chk("skid_out_inst", if_inst, 32'd8);
        chk("skid_next_addr", imem_addr, 32'd12);
        chk("skid_next_req", imem_req, 1'b1);

        branch_flag   = 1'b1;
        branch_target = 32'h203;
        tick();
        branch_flag = 1'b0;
        chk("brack_valid", if_valid, 1'b0);
        chk("brack_addr", imem_addr, 32'h200);
        tick();
        chk("brack_pc", if_pc, 32'h200);
        chk("brack_v", if_valid, 1'b1);

        ack_mode = 1'b0;
        ack_drv  = 1'b0;
        tick();
        chk("noack_valid", if_valid, 1'b0);
        branch_flag   = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_flag = 1'b0;
        chk("disc_req", imem_req, 1'b1);
        chk("disc_addr0", imem_addr, 32'h204);
        chk("disc_valid", if_valid, 1'b0);
        tick();
        chk("disc_addr1", imem_addr, 32'h204);
        tick();
        chk("disc_addr2", imem_addr, 32'h204);
        ack_drv = 1'b1;
        tick();
        chk("disc_drop_v", if_valid, 1'b0);
        chk("disc_new_addr", imem_addr, 32'h100);
        tick();
        ack_drv = 1'b0;
        chk("disc_pc", if_pc, 32'h100);
        chk("disc_inst", if_inst, 32'h100);
        chk("disc_v", if_valid, 1'b1);
        chk("disc_next", imem_addr, 32'h104);

        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", imem_req, 1'b0);
        chk("arst_valid", if_valid, 1'b0);
        chk("arst_pc", if_pc, 32'd0);
        chk("arst_inst", if_inst, 32'd0);
        ack_drv = 1'b1;
        tick();
        chk("rst_ack_req", imem_req, 1'b0);
        chk("rst_ack_v", if_valid, 1'b0);
        salt = 32'hA5A5_5A5A;
        rst  = 1'b0;
        tick();
        chk("idle_ack_v", if_valid, 1'b0);
        chk("idle_ack_addr", imem_addr, 32'd0);

        exp_q.delete();
        gen_pc = 32'd0;
        top_up();
        sb_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall   = ($urandom_range(0, 9) < 3);
            ack_drv = ($urandom_range(0, 9) < 6);
            junk    = $urandom;
            if ($urandom_range(0, 99) < 7) begin
                branch_flag   = 1'b1;
                branch_target = $urandom;
                exp_q.delete();
                gen_pc = {branch_target[31:2], 2'b00};
            end else begin
                branch_flag = 1'b0;
            end
            top_up();
            tick();
        end
        sb_on = 1'b0;
        total++;
        if (pops < 200) begin
            bad++;
            $display("FAIL progress: got %0d consumed expected at least 200",
                     pops);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, downstream pipeline register cannot accept this cycle.
REQ-005 SHALL have port branch_flag, input, 1, redirect pulse, qualified per cycle.
REQ-006 SHALL have port branch_target, input, 32, redirect address, valid when branch_flag=1.
REQ-007 SHALL have port imem_req, output, 1, instruction memory request.
REQ-008 SHALL have port imem_addr, output, 32, word address of the request.
REQ-009 SHALL have port imem_ack, input, 1, memory response; imem_rdata valid in the same cycle.
REQ-010 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-011 SHALL have port if_pc, output, 32, PC of the presented instruction.
REQ-012 SHALL have port if_inst, output, 32, presented instruction.
REQ-013 SHALL have port if_valid, output, 1, if_pc and if_inst hold a live instruction.

Function
REQ-014 SHALL implement states IDLE, FETCH, WAIT_OUT, DISCARD; imem_req=1 only in FETCH and DISCARD.
REQ-015 IDLE SHALL move to FETCH unconditionally on the next edge.
REQ-016 imem_addr SHALL equal the internal pc, and imem_req and imem_addr SHALL stay stable from first assertion until the cycle imem_ack=1.
REQ-017 imem_ack in the same cycle as imem_req SHALL be accepted, giving one instruction per cycle with a zero-wait memory.
REQ-018 An output slot is free when if_valid=0, or when if_valid=1 and stall=0 (consumed at this edge).
REQ-019 FETCH with ack and slot free: if_pc<=pc, if_inst<=imem_rdata, if_valid<=1, pc<=pc+4, remain FETCH.
REQ-020 FETCH with ack and slot not free: capture {pc, imem_rdata} in a one-entry skid buffer, pc<=pc+4, go WAIT_OUT.
REQ-021 FETCH with no ack and slot free: if_valid<=0.
REQ-022 WAIT_OUT: outputs hold while stall=1; when stall=0, load outputs from skid, if_valid<=1, go FETCH.
REQ-023 pc+4 SHALL be modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-024 branch_flag SHALL have priority over all other events: if_valid<=0, skid emptied, pc<={branch_target[31:2],2'b00}.
REQ-025 branch_flag in FETCH without ack: go DISCARD with imem_addr held at the old address.
REQ-026 branch_flag in FETCH with ack in the same cycle: response discarded, remain FETCH at the new pc.
REQ-027 DISCARD: keep the request until ack, drop the data, then go FETCH; a further branch_flag in DISCARD SHALL only update pc.
REQ-028 branch_flag in IDLE or WAIT_OUT SHALL go FETCH at the new pc.
REQ-029 if_pc/if_inst SHALL hold their last values whenever if_valid=0 or stall=1.

Reset
REQ-030 rst=1 SHALL immediately, without clk: state=IDLE, pc=RESET_PC, imem_req=0, if_valid=0, if_pc=0, if_inst=0, skid empty.
REQ-031 Reset asserted mid-request SHALL abandon the request; any ack while rst=1 or in IDLE SHALL be ignored.

Verification
REQ-032 Reset release, zero-wait memory returning addr as data -> 1 idle cycle, then if_pc=0,4,8 with if_valid=1 on consecutive cycles.
REQ-033 stall=1 while if_valid=1 and ack arrives for pc=8 -> skid filled, imem_req=0, outputs hold pc=4; stall=0 -> if_pc=8, next request addr=12.
REQ-034 branch_flag with target 32'h100 while ack delayed 3 cycles -> imem_addr held old, data dropped, if_valid=0, next request addr 32'h100.
REQ-035 branch_flag with ack in the same cycle, target 32'h203 -> data dropped, next imem_addr=32'h200.
REQ-036 RESET_PC=32'hFFFF_FFFC -> first if_pc=32'hFFFF_FFFC, second if_pc=32'h0.
REQ-037 rst pulse between clock edges during an outstanding request -> imem_req, if_valid, if_pc, if_inst read 0 before the next edge.
